// File: rtl/mesh_flit_serializer.sv
// mesh_flit_serializer
//
// Source-side stage of the mesh link. Spike packets from the neuron-side packet
// generator are buffered in a small packet FIFO. Each packet is then serialized
// MS flit first onto the flit stream that feeds mesh_controller. A flit moves
// downstream on every rising edge where write_enable is high and receive_full
// is low. While receive_full is high, the flit, the valid flag and the shift
// state all hold.
//
// Ports:
//   rt_clk        in   single clock, rising edge
//   rt_reset      in   synchronous active-high reset
//   spike_packet  in   packet to enqueue
//   packet_valid  in   spike_packet is valid
//   packet_ready  out  FIFO can accept a packet (low while full or in reset)
//   receive_full  in   downstream cannot take a flit this cycle
//   flit_out      out  current flit (registered)
//   write_enable  out  flit_out is valid (registered)
//   fifo_count    out  packets buffered, not counting the one being serialized
//   busy          out  serializer is in the SEND state

module mesh_flit_serializer #(
  parameter int unsigned PACKET_WIDTH = 32,
  parameter int unsigned FLIT_WIDTH   = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          rt_clk,
  input  logic                          rt_reset,
  input  logic [PACKET_WIDTH-1:0]       spike_packet,
  input  logic                          packet_valid,
  output logic                          packet_ready,
  input  logic                          receive_full,
  output logic [FLIT_WIDTH-1:0]         flit_out,
  output logic                          write_enable,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int unsigned NFLITS = PACKET_WIDTH / FLIT_WIDTH;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned FCNT_W = (NFLITS > 1) ? $clog2(NFLITS) : 1;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  // Packet FIFO storage and bookkeeping
  logic [PACKET_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;

  // Serializer state
  state_e                  state_q, state_d;
  logic [PACKET_WIDTH-1:0] shift_q, shift_d;
  logic [FCNT_W-1:0]       flit_cnt_q, flit_cnt_d;
  logic [FLIT_WIDTH-1:0]   flit_q, flit_d;
  logic                    we_q, we_d;

  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    push;
  logic                    pop;
  logic                    transfer;
  logic                    last_flit;
  logic [PACKET_WIDTH-1:0] head;
  logic [PACKET_WIDTH-1:0] shifted;

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  // No push-through on a full FIFO, even when the same edge pops.
  assign packet_ready = !fifo_full && !rt_reset;
  assign push         = packet_valid && packet_ready;

  assign transfer  = we_q && !receive_full;
  assign last_flit = (flit_cnt_q == FCNT_W'(NFLITS - 1));
  assign head      = fifo_mem[rd_ptr_q];
  assign shifted   = shift_q << FLIT_WIDTH;

  // Next-state logic for the serializer. Pop decisions look only at the
  // registered count, so a packet pushed this edge is never bypassed.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    flit_cnt_d = flit_cnt_q;
    flit_d     = flit_q;
    we_d       = we_q;
    pop        = 1'b0;

    unique case (state_q)
      StIdle: begin
        we_d   = 1'b0;
        flit_d = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_d    = head;
          flit_cnt_d = '0;
          flit_d     = head[PACKET_WIDTH-1 -: FLIT_WIDTH];
          we_d       = 1'b1;
          state_d    = StSend;
        end
      end

      StSend: begin
        // Without a transfer everything holds (stall).
        if (transfer) begin
          if (!last_flit) begin
            shift_d    = shifted;
            flit_d     = shifted[PACKET_WIDTH-1 -: FLIT_WIDTH];
            flit_cnt_d = flit_cnt_q + FCNT_W'(1);
          end else if (!fifo_empty) begin
            // Chain straight into the next packet with no bubble.
            pop        = 1'b1;
            shift_d    = head;
            flit_cnt_d = '0;
            flit_d     = head[PACKET_WIDTH-1 -: FLIT_WIDTH];
            we_d       = 1'b1;
          end else begin
            shift_d    = '0;
            flit_cnt_d = '0;
            flit_d     = '0;
            we_d       = 1'b0;
            state_d    = StIdle;
          end
        end
      end

      default: begin
        state_d = StIdle;
        we_d    = 1'b0;
        flit_d  = '0;
      end
    endcase
  end

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset; only the pointers and count define its contents.
  always_ff @(posedge rt_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= spike_packet;
    end
  end

  always_ff @(posedge rt_clk) begin
    if (rt_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= StIdle;
      shift_q    <= '0;
      flit_cnt_q <= '0;
      flit_q     <= '0;
      we_q       <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      flit_cnt_q <= flit_cnt_d;
      flit_q     <= flit_d;
      we_q       <= we_d;
    end
  end

  assign flit_out     = flit_q;
  assign write_enable = we_q;
  assign fifo_count   = count_q;
  assign busy         = (state_q == StSend);

endmodule

// File: tb/tb_mesh_flit_serializer.sv
// Self-checking bench for mesh_flit_serializer. A queue-based reference model
// (packet queue plus the flits still owed by the packet in flight) predicts
// every output after every edge. Directed checks confirm the end-to-end flit
// sequences, the cycle counts and the boundary cases.

module tb_mesh_flit_serializer;

  localparam int unsigned PW    = 32;
  localparam int unsigned FW    = 4;
  localparam int unsigned NF    = PW / FW;
  localparam int unsigned DEPTH = 4;

  logic          rt_clk;
  logic          rt_reset;
  logic [PW-1:0] spike_packet;
  logic          packet_valid;
  logic          packet_ready;
  logic          receive_full;
  logic [FW-1:0] flit_out;
  logic          write_enable;
  logic [2:0]    fifo_count;
  logic          busy;

  mesh_flit_serializer #(
    .PACKET_WIDTH (PW),
    .FLIT_WIDTH   (FW),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .rt_clk       (rt_clk),
    .rt_reset     (rt_reset),
    .spike_packet (spike_packet),
    .packet_valid (packet_valid),
    .packet_ready (packet_ready),
    .receive_full (receive_full),
    .flit_out     (flit_out),
    .write_enable (write_enable),
    .fifo_count   (fifo_count),
    .busy         (busy)
  );

  initial rt_clk = 1'b0;
  always #5 rt_clk = ~rt_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] mq[$];      // packets waiting in the FIFO
  logic [3:0]  cur[$];     // flits still owed by the packet in flight
  bit          active = 1'b0;

  logic [3:0]  log_q[$];   // flits actually transferred by the DUT
  logic [31:0] exp_pk[$];
  int          we_cycles;
  int          max_cnt;

  bit bp_pat [15] = '{0, 0, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] log_word(input int p);
    logic [31:0] w = '0;
    for (int i = 0; i < NF; i++) w = (w << 4) | 32'(log_q[p * NF + i]);
    return w;
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, check outputs.
  task automatic step(input logic v, input logic [31:0] d, input logic rf, input logic rst);
    logic [31:0] pk;
    bit          push;
    bit          pop;
    packet_valid = v;
    spike_packet = d;
    receive_full = rf;
    rt_reset     = rst;
    if (!rst && write_enable === 1'b1 && !rf) log_q.push_back(flit_out);
    @(posedge rt_clk);
    if (rst) begin
      mq.delete();
      cur.delete();
      active = 1'b0;
    end else begin
      push = v && (mq.size() < DEPTH);
      pop  = 1'b0;
      if (!active) begin
        pop = (mq.size() > 0);
      end else if (!rf) begin
        void'(cur.pop_front());
        if (cur.size() == 0) pop = (mq.size() > 0);
      end
      if (pop) begin
        pk = mq.pop_front();
        for (int k = 0; k < NF; k++) cur.push_back(pk[31 - 4 * k -: 4]);
        active = 1'b1;
      end else if (active && cur.size() == 0) begin
        active = 1'b0;
      end
      if (push) mq.push_back(d);
    end
    #1;
    chk("write_enable", 32'(write_enable), 32'(active));
    chk("flit_out", 32'(flit_out), active ? 32'(cur[0]) : 32'h0);
    chk("busy", 32'(busy), 32'(active));
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("packet_ready", 32'(packet_ready), 32'((mq.size() < DEPTH) && !rst));
    if (write_enable === 1'b1) we_cycles++;
    if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    int n_push;
    int cyc;
    logic        v;
    logic        rf;
    logic [31:0] d;

    packet_valid = 1'b0;
    spike_packet = '0;
    receive_full = 1'b0;
    rt_reset     = 1'b1;

    // Reset, with packet_valid asserted to show it is ignored
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
    chk("reset_ready_low", 32'(packet_ready), 32'h0);
    chk("reset_count", 32'(fifo_count), 32'h0);
    idle(2);

    // Single packet
    log_q.delete();
    we_cycles = 0;
    step(1'b1, 32'h12345678, 1'b0, 1'b0);
    chk("single_count_after_push", 32'(fifo_count), 32'h1);
    chk("single_we_after_push", 32'(write_enable), 32'h0);
    idle(12);
    chk("single_we_cycles", 32'(we_cycles), 32'd8);
    chk("single_flit_count", 32'(log_q.size()), 32'd8);
    if (log_q.size() >= NF) chk("single_word", log_word(0), 32'h12345678);

    // Burst to full under backpressure, then drain
    for (int i = 1; i <= 5; i++) step(1'b1, 32'hA000_0000 + 32'(i), 1'b1, 1'b0);
    chk("burst_ready_low", 32'(packet_ready), 32'h0);
    chk("burst_count", 32'(fifo_count), 32'd4);
    chk("burst_first_flit", 32'(flit_out), 32'hA);
    step(1'b1, 32'hA0000006, 1'b1, 1'b0);  // refused: FIFO full
    log_q.delete();
    idle(45);
    chk("burst_flit_count", 32'(log_q.size()), 32'd40);
    for (int p = 0; p < 5; p++)
      if (log_q.size() >= NF * (p + 1))
        chk("burst_word", log_word(p), 32'hA000_0001 + 32'(p));

    // Backpressure on flits 3..5, two cycles each
    log_q.delete();
    we_cycles = 0;
    step(1'b1, 32'hFEDCBA98, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b0, 32'h0, bp_pat[i], 1'b0);
    idle(3);
    chk("bp_we_cycles", 32'(we_cycles), 32'd14);
    chk("bp_flit_count", 32'(log_q.size()), 32'd8);
    if (log_q.size() >= NF) chk("bp_word", log_word(0), 32'hFEDCBA98);

    // Push on the same edge as the last-flit transfer with two packets queued
    step(1'b1, 32'h11112222, 1'b0, 1'b0);
    step(1'b1, 32'h5A5A5A5A, 1'b0, 1'b0);
    step(1'b1, 32'h33334444, 1'b0, 1'b0);
    chk("pp_count_before", 32'(fifo_count), 32'd2);
    idle(6);
    step(1'b1, 32'h66667777, 1'b0, 1'b0);
    chk("pp_count_held", 32'(fifo_count), 32'd2);
    chk("pp_no_bubble", 32'(write_enable), 32'h1);
    chk("pp_next_first_flit", 32'(flit_out), 32'h5);
    idle(30);

    // Reset in the middle of a packet with two more queued
    step(1'b1, 32'h13572468, 1'b0, 1'b0);
    step(1'b1, 32'h24681357, 1'b0, 1'b0);
    step(1'b1, 32'h99990000, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("midrst_we", 32'(write_enable), 32'h0);
    chk("midrst_count", 32'(fifo_count), 32'h0);
    chk("midrst_flit", 32'(flit_out), 32'h0);
    we_cycles = 0;
    idle(20);
    chk("midrst_no_flits", 32'(we_cycles), 32'h0);

    // Randomized stream exercising pointer wrap
    log_q.delete();
    exp_pk.delete();
    max_cnt = 0;
    n_push  = 0;
    cyc     = 0;
    while (n_push < 10 && cyc < 400) begin
      v  = 1'($urandom_range(0, 1));
      d  = $urandom;
      rf = ($urandom_range(0, 3) == 0);
      if (v && mq.size() < DEPTH) begin
        exp_pk.push_back(d);
        n_push++;
      end
      step(v, d, rf, 1'b0);
      cyc++;
    end
    cyc = 0;
    while ((active || mq.size() > 0) && cyc < 600) begin
      step(1'b0, 32'h0, ($urandom_range(0, 3) == 0), 1'b0);
      cyc++;
    end
    chk("rand_drained", 32'(active || mq.size() > 0), 32'h0);
    idle(1);
    chk("rand_flit_count", 32'(log_q.size()), 32'(NF * exp_pk.size()));
    for (int p = 0; p < exp_pk.size(); p++)
      if (log_q.size() >= NF * (p + 1))
        chk("rand_word", log_word(p), exp_pk[p]);
    chk("rand_max_count", 32'(max_cnt <= DEPTH), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
